// File: rtl/adder_issue_buffer.sv
// Adder reservation buffer: dispatch fills the lowest free slot, issue pops
// any valid slot out of order. Every slot is exposed in parallel.
module adder_issue_buffer #(
   parameter int DW = 157,
   parameter int DP = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   adder_dispat_push,
   input  logic [DW-1:0]          adder_dispat_info,
   output logic                   adder_buffer_full,
   output logic [$clog2(DP):0]    adder_buffer_cnt,
   input  logic                   adder_buffer_pop,
   input  logic [$clog2(DP)-1:0]  adder_buffer_pop_index,
   output logic [DP-1:0]          adder_buffer_malloc,
   output logic [DW*DP-1:0]       adder_issue_info,
   input  logic                   flush
);

   localparam int IW = $clog2(DP);
   localparam int CW = IW + 1;

   logic [DP-1:0] malloc;
   logic [DW-1:0] info [DP];
   logic [CW-1:0] cnt;

   logic [IW-1:0] push_idx;
   logic          full;
   logic          push_acc;
   logic          pop_acc;
   logic [DP-1:0] malloc_nxt;
   logic [CW-1:0] cnt_nxt;

   assign full = &malloc;

   // Lowest free slot from the pre-pop bitmap; meaningless when full.
   always_comb begin
      push_idx = '0;
      for (int i = DP - 1; i >= 0; i--) begin
         if (!malloc[i]) push_idx = IW'(i);
      end
   end

   assign push_acc = adder_dispat_push & ~full & ~flush;
   assign pop_acc  = adder_buffer_pop & malloc[adder_buffer_pop_index] & ~flush;

   always_comb begin
      malloc_nxt = malloc;
      cnt_nxt    = cnt + CW'(push_acc) - CW'(pop_acc);
      if (pop_acc)  malloc_nxt[adder_buffer_pop_index] = 1'b0;
      if (push_acc) malloc_nxt[push_idx] = 1'b1;
      if (flush) begin
         malloc_nxt = '0;
         cnt_nxt    = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         malloc <= '0;
         cnt    <= '0;
      end else begin
         malloc <= malloc_nxt;
         cnt    <= cnt_nxt;
      end
   end

   // Popped and flushed slots keep stale payload; malloc masks it.
   always_ff @(posedge CLK) begin
      for (int i = 0; i < DP; i++) begin
         if (RST) begin
            info[i] <= '0;
         end else if (push_acc && push_idx == IW'(i)) begin
            info[i] <= adder_dispat_info;
         end
      end
   end

   assign adder_buffer_full   = full;
   assign adder_buffer_cnt    = cnt;
   assign adder_buffer_malloc = malloc;

   for (genvar g = 0; g < DP; g++) begin : g_out
      assign adder_issue_info[DW*g +: DW] = info[g];
   end

endmodule

// File: tb/tb_adder_issue_buffer.sv
// Scoreboard bench for adder_issue_buffer: directed occupancy cases with
// hand-written bitmap/count, then a long random push/pop/flush run.
module tb_adder_issue_buffer;

   localparam int DW = 157;
   localparam int DP = 4;
   localparam int IW = 2;
   localparam int CW = 3;

   logic               CLK = 1'b0;
   logic               RST;
   logic               push;
   logic [DW-1:0]      dinfo;
   logic               full;
   logic [CW-1:0]      cnt;
   logic               pop;
   logic [IW-1:0]      pidx;
   logic [DP-1:0]      malloc;
   logic [DW*DP-1:0]   issue_info;
   logic               flush;

   adder_issue_buffer #(.DW(DW), .DP(DP)) dut (
      .CLK                    (CLK),
      .RST                    (RST),
      .adder_dispat_push      (push),
      .adder_dispat_info      (dinfo),
      .adder_buffer_full      (full),
      .adder_buffer_cnt       (cnt),
      .adder_buffer_pop       (pop),
      .adder_buffer_pop_index (pidx),
      .adder_buffer_malloc    (malloc),
      .adder_issue_info       (issue_info),
      .flush                  (flush)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [DP-1:0]    m;
      logic [CW-1:0]    c;
      logic [DW*DP-1:0] inf;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   logic [DP-1:0]    m_mal = '0;
   logic [CW-1:0]    m_cnt = '0;
   logic [DW*DP-1:0] m_inf = '0;

   function automatic logic [DW-1:0] pat(input logic [3:0] k);
      logic [159:0] w;
      w = {40{k}};
      return w[DW-1:0];
   endfunction

   task automatic step(
      input logic          p,
      input logic [DW-1:0] d,
      input logic          po,
      input logic [IW-1:0] pi,
      input logic          fl,
      input logic          rs,
      input bit            hand,
      input logic [DP-1:0] hm,
      input int            hc
   );
      exp_t          e;
      logic          f;
      logic          pa;
      logic          oa;
      logic [IW-1:0] fi;
      @(negedge CLK);
      push = p; dinfo = d; pop = po; pidx = pi; flush = fl; RST = rs;
      f  = &m_mal;
      fi = '0;
      for (int i = DP - 1; i >= 0; i--) if (!m_mal[i]) fi = IW'(i);
      pa = p & ~f & ~fl;
      oa = po & m_mal[pi] & ~fl;
      e.m   = m_mal;
      e.inf = m_inf;
      if (oa) e.m[pi] = 1'b0;
      if (pa) begin
         e.m[fi] = 1'b1;
         e.inf[DW*fi +: DW] = d;
      end
      e.c = m_cnt + CW'(pa) - CW'(oa);
      if (fl) begin
         e.m = '0;
         e.c = '0;
      end
      if (rs) begin
         e.m = '0; e.c = '0; e.inf = '0;
      end
      if (hand) begin
         e.m = hm;
         e.c = CW'(hc);
      end
      @(posedge CLK);
      q.push_back(e);
      m_mal = e.m; m_cnt = e.c; m_inf = e.inf;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks += 4;
         if (malloc !== e.m) begin
            errors++;
            $display("FAIL malloc got=%b exp=%b", malloc, e.m);
         end
         if (cnt !== e.c) begin
            errors++;
            $display("FAIL cnt got=%0d exp=%0d", cnt, e.c);
         end
         if (full !== (&e.m)) begin
            errors++;
            $display("FAIL full got=%b exp=%b", full, &e.m);
         end
         if (issue_info !== e.inf) begin
            errors++;
            for (int i = 0; i < DP; i++)
               if (issue_info[DW*i +: DW] !== e.inf[DW*i +: DW])
                  $display("FAIL info slot%0d got=%h exp=%h", i,
                           issue_info[DW*i +: DW], e.inf[DW*i +: DW]);
         end
      end
   end

   initial begin
      logic          rp, rpo, rfl;
      logic [IW-1:0] ri;
      logic [DW-1:0] rd;
      push = 0; dinfo = '0; pop = 0; pidx = '0; flush = 0; RST = 1;

      step(0, '0, 0, 0, 0, 1, 1, 4'b0000, 0);
      step(1, pat(1), 0, 0, 0, 0, 1, 4'b0001, 1);
      step(1, pat(2), 0, 0, 0, 0, 1, 4'b0011, 2);
      step(1, pat(3), 0, 0, 0, 0, 1, 4'b0111, 3);
      step(1, pat(4), 0, 0, 0, 0, 1, 4'b1111, 4);
      step(1, pat(5), 1, 2, 0, 0, 1, 4'b1011, 3);
      step(1, pat(6), 0, 0, 0, 0, 1, 4'b1111, 4);
      step(0, '0, 1, 1, 0, 0, 1, 4'b1101, 3);
      step(0, '0, 1, 3, 0, 0, 1, 4'b0101, 2);
      step(1, pat(7), 1, 0, 0, 0, 1, 4'b0110, 2);
      step(0, '0, 1, 1, 0, 0, 1, 4'b0100, 1);
      step(0, '0, 1, 2, 0, 0, 1, 4'b0000, 0);
      step(1, pat(8), 0, 0, 0, 0, 1, 4'b0001, 1);
      step(0, '0, 1, 3, 0, 0, 1, 4'b0001, 1);
      step(1, pat(9), 0, 0, 0, 0, 1, 4'b0011, 2);
      step(1, pat(10), 0, 0, 0, 0, 1, 4'b0111, 3);
      step(1, pat(11), 0, 0, 0, 0, 1, 4'b1111, 4);
      step(1, pat(12), 1, 0, 1, 0, 1, 4'b0000, 0);
      step(1, pat(13), 1, 0, 0, 0, 1, 4'b0001, 1);
      step(1, pat(14), 0, 0, 0, 1, 1, 4'b0000, 0);

      for (int n = 0; n < 10000; n++) begin
         rp  = ($urandom_range(0, 9) < 6);
         rpo = ($urandom_range(0, 9) < 5);
         rfl = ($urandom_range(0, 63) == 0);
         ri  = IW'($urandom_range(0, DP - 1));
         rd  = {$urandom, $urandom, $urandom, $urandom, $urandom};
         step(rp, rd, rpo, ri, rfl, 0, 0, '0, 0);
      end

      @(negedge CLK);
      push = 0; pop = 0; flush = 0;
      repeat (2) @(negedge CLK);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d exp=0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_issue_buffer.md
# adder_issue_buffer

Reservation buffer between dispatch and the adder issue stage. Holds up to DP decoded adder micro-ops (lui/auipc/addi/addiw/add/addw/sub/subw plus pc, imm, rd0, rs1, rs2) in slots tracked by a per-slot valid bitmap. Exposes every slot in parallel so issue can pick any RAW-clear entry out of order, and frees the slot that issue pops. Dispatch writes one entry per cycle into the lowest free slot.

## Interface
- DW, default 157: width of one packed issue-info entry (8 op flags + 64 pc + 64 imm + 3×(5+`RB) with `RB=2).
- DP, default 4: number of slots; power of two, ≥2.

- CLK  input  1  clock, all state on rising edge.
- RST  input  1  synchronous, active-high reset.
- adder_dispat_push  input  1  dispatch writes adder_dispat_info this cycle.
- adder_dispat_info  input  DW  packed entry, same field order as one slot of adder_issue_info.
- adder_buffer_full  output  1  all slots allocated; dispatch must not push.
- adder_buffer_cnt  output  $clog2(DP)+1  number of allocated slots.
- adder_buffer_pop  input  1  issue consumes slot adder_buffer_pop_index this cycle.
- adder_buffer_pop_index  input  $clog2(DP)  slot being popped.
- adder_buffer_malloc  output  DP  bit i = slot i holds a valid entry.
- adder_issue_info  output  DW*DP  slot i at [DW*i +: DW].
- flush  input  1  pipeline flush; discard all entries.

## Operation
- State: malloc[DP] register, info[DP][DW] register array, cnt register.
- Allocation: push_idx = lowest i with malloc[i]==0, evaluated on current (pre-pop) malloc. Push accepted iff adder_dispat_push & ~adder_buffer_full & ~flush.
- Accepted push: info[push_idx] <= adder_dispat_info; malloc[push_idx] <= 1.
- Pop accepted iff adder_buffer_pop & malloc[pop_index] & ~flush; clears malloc[pop_index]. info contents of popped slot left unchanged (stale, masked by malloc).
- Pop of unallocated slot: ignored, no state change.
- Push while full: ignored, no state change, even if a pop is accepted same cycle (no pop-to-push bypass).
- Simultaneous accepted push and pop: always different slots (push slot free, pop slot allocated); both take effect; cnt unchanged.
- cnt next = cnt + push_acc − pop_acc; never exceeds DP or underflows.
- flush: malloc <= 0, cnt <= 0; overrides push and pop same cycle; info untouched.
- adder_buffer_full = &malloc (combinational from register). adder_buffer_malloc, adder_issue_info, adder_buffer_cnt driven directly from registers.
- Reset (RST=1 at edge): malloc=0, cnt=0, all info=0; hence adder_buffer_full=0, adder_buffer_malloc=0, adder_issue_info=0, adder_buffer_cnt=0 in the cycle after reset. RST overrides flush, push, pop.
- Invariant: cnt == popcount(malloc) at all times.

## Timing
- Push→visible: entry pushed in cycle N appears in adder_buffer_malloc/adder_issue_info in cycle N+1; earliest pop cycle N+1.
- Pop→free: slot popped in cycle N reads malloc=0 in N+1; earliest reuse by push in N+1.
- adder_buffer_full updated the cycle after the push/pop that changed occupancy; dispatch sampling full in cycle N gets a state-consistent answer for a push in cycle N.
- Issue stage pops combinationally from this cycle's outputs; no internal combinational path from adder_buffer_pop to any output.
- Sustained throughput: one push and one pop per cycle with no bubble when not full.

## Test plan
- Reset then push 4 entries (info = 0x1…, 0x2…, 0x3…, 0x4…) on consecutive cycles -> malloc steps 0001,0011,0111,1111; full=1 and cnt=4 after 4th; slot i holds the i-th info.
- Full buffer, push info 0x5… with pop index 2 same cycle -> push ignored; next cycle malloc=1011, cnt=3; following push lands in slot 2.
- malloc=0101, push + pop index 0 same cycle -> push goes to slot 1; next cycle malloc=0110, cnt=2.
- Pop index 3 while malloc=0001 -> no change; malloc stays 0001, cnt=1.
- malloc=1111, flush with push and pop asserted -> next cycle malloc=0000, cnt=0, full=0; info of all slots unchanged.
- Random push/pop/flush for 10k cycles with scoreboard -> cnt==popcount(malloc), no overwrite of allocated slot, popped info matches pushed info.
